// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
//   Bundles the control strobes, branch/return targets, instruction-memory
//   bus and decoded-field outputs of the program-counter / fetch datapath.
//
//   master : the side that drives the strobes and instruction memory data
//            (PC control unit + memory), and observes PC/IR state.
//   slave  : the pc_fetch datapath itself.
//
//   Strobes      : pc_en, pc_load, pc_src[1:0], addr_src[1:0], byte_sel,
//                  if_en, instr_done
//   Targets      : rb_ex, rb_d, stack_data (8 bits each)
//   Memory bus   : imem_addr (to memory), imem_rdata (from memory, comb.)
//   State/fields : pc, ret_addr, ir, opcode, brx, rb_idx, imm, ir_valid,
//                  imm_valid, epc, retired
// -----------------------------------------------------------------------------
interface pc_fetch_if;
  // Control strobes from the PC control unit
  logic        pc_en;
  logic        pc_load;
  logic [1:0]  pc_src;
  logic [1:0]  addr_src;
  logic        byte_sel;
  logic        if_en;
  logic        instr_done;

  // Load targets
  logic [7:0]  rb_ex;
  logic [7:0]  rb_d;
  logic [7:0]  stack_data;

  // Instruction memory bus
  logic [7:0]  imem_addr;
  logic [7:0]  imem_rdata;

  // PC / instruction state and decoded fields
  logic [7:0]  pc;
  logic [7:0]  ret_addr;
  logic [7:0]  ir;
  logic [3:0]  opcode;
  logic [1:0]  brx;
  logic [1:0]  rb_idx;
  logic [7:0]  imm;
  logic        ir_valid;
  logic        imm_valid;
  logic [7:0]  epc;
  logic [15:0] retired;

  modport master (
    output pc_en, pc_load, pc_src, addr_src, byte_sel, if_en, instr_done,
    output rb_ex, rb_d, stack_data, imem_rdata,
    input  imem_addr, pc, ret_addr, ir, opcode, brx, rb_idx, imm,
    input  ir_valid, imm_valid, epc, retired
  );

  modport slave (
    input  pc_en, pc_load, pc_src, addr_src, byte_sel, if_en, instr_done,
    input  rb_ex, rb_d, stack_data, imem_rdata,
    output imem_addr, pc, ret_addr, ir, opcode, brx, rb_idx, imm,
    output ir_valid, imm_valid, epc, retired
  );
endinterface

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Program-counter and instruction-fetch datapath. Holds the 8-bit PC,
//   drives the instruction-memory address, captures the opcode byte (IR) and
//   the optional immediate/EA byte (IMM), records the PC at interrupt entry
//   (EPC) and counts retired instructions.
//
//   Parameters
//     RESET_VEC_ADDR : memory address holding the reset vector
//     INTR_VEC_ADDR  : memory address holding the interrupt vector
//
//   Ports
//     clk   : clock, rising edge
//     reset : synchronous, active-high; clears all state
//     bus   : pc_fetch_if.slave (strobes, targets, memory bus, outputs)
//
//   The memory address is chosen so that the byte fetched on an edge is the
//   byte at the address the PC holds after that edge; fetch latency is one
//   cycle and a load is followed by a non-incrementing fetch of the target.
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] INTR_VEC_ADDR  = 8'h01
) (
  input logic       clk,
  input logic       reset,
  pc_fetch_if.slave bus
);

  // pc_src encodings
  localparam logic [1:0] SRC_RB_EX  = 2'b00;
  localparam logic [1:0] SRC_VECTOR = 2'b01;
  localparam logic [1:0] SRC_RB_D   = 2'b10;
  localparam logic [1:0] SRC_STACK  = 2'b11;

  // addr_src encodings (2'b11 falls through to the PC-relative path)
  localparam logic [1:0] ADDR_RESET = 2'b01;
  localparam logic [1:0] ADDR_INTR  = 2'b10;

  localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

  // State registers
  logic [7:0]  pc_q,        pc_d;
  logic [7:0]  ir_q,        ir_d;
  logic [7:0]  imm_q,       imm_d;
  logic        ir_valid_q,  ir_valid_d;
  logic        imm_valid_q, imm_valid_d;
  logic [7:0]  epc_q,       epc_d;
  logic [15:0] retired_q,   retired_d;

  // Datapath intermediates
  logic [7:0]  pc_inc_s;
  logic [7:0]  load_val_s;
  logic        pc_step_s;
  logic        pc_take_s;
  logic        vector_load_s;
  logic        ir_write_s;
  logic        imm_write_s;
  logic [7:0]  imem_addr_s;

  // Strobe decode and PC increment
  always_comb begin
    pc_inc_s      = pc_q + 8'd1;
    pc_take_s     = bus.pc_en & bus.pc_load;
    pc_step_s     = bus.pc_en & ~bus.pc_load;
    // A load without pc_en is ignored entirely, including its vector side effects.
    vector_load_s = pc_take_s & (bus.pc_src == SRC_VECTOR);
    ir_write_s    = bus.if_en & ~bus.byte_sel & ~bus.pc_load;
    imm_write_s   = bus.if_en & bus.byte_sel;
  end

  // PC load-source mux
  always_comb begin
    load_val_s = bus.rb_ex;
    case (bus.pc_src)
      SRC_RB_EX:  load_val_s = bus.rb_ex;
      SRC_VECTOR: load_val_s = bus.imem_rdata;
      SRC_RB_D:   load_val_s = bus.rb_d;
      SRC_STACK:  load_val_s = bus.stack_data;
      default:    load_val_s = bus.rb_ex;
    endcase
  end

  // Instruction memory address: vector slots, else the PC value after this edge
  always_comb begin
    imem_addr_s = pc_q;
    case (bus.addr_src)
      ADDR_RESET: imem_addr_s = RESET_VEC_ADDR;
      ADDR_INTR:  imem_addr_s = INTR_VEC_ADDR;
      default: begin
        if (pc_step_s) begin
          imem_addr_s = pc_inc_s;
        end else begin
          imem_addr_s = pc_q;
        end
      end
    endcase
  end

  // Next-state logic for PC
  always_comb begin
    pc_d = pc_q;
    if (pc_take_s) begin
      pc_d = load_val_s;
    end else if (pc_step_s) begin
      pc_d = pc_inc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Next-state logic for IR, IMM, their valid flags and EPC
  always_comb begin
    ir_d        = ir_q;
    imm_d       = imm_q;
    ir_valid_d  = ir_valid_q;
    imm_valid_d = imm_valid_q;
    epc_d       = epc_q;

    // A new opcode byte invalidates any immediate left from the previous instruction.
    if (ir_write_s) begin
      ir_d        = bus.imem_rdata;
      ir_valid_d  = 1'b1;
      imm_valid_d = 1'b0;
    end else begin
      ir_d        = ir_q;
    end

    if (imm_write_s) begin
      imm_d       = bus.imem_rdata;
      imm_valid_d = 1'b1;
    end else begin
      imm_d       = imm_q;
    end

    // Vector entry abandons the current instruction; the flags clear last so
    // they win over a concurrent fetch strobe.
    if (vector_load_s) begin
      ir_valid_d  = 1'b0;
      imm_valid_d = 1'b0;
      if (bus.addr_src == ADDR_INTR) begin
        epc_d = pc_q;
      end else begin
        epc_d = epc_q;
      end
    end else begin
      epc_d = epc_q;
    end
  end

  // Next-state logic for the saturating retire counter
  always_comb begin
    retired_d = retired_q;
    if (bus.instr_done && (retired_q != RETIRED_MAX)) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= 8'h00;
      ir_q        <= 8'h00;
      imm_q       <= 8'h00;
      ir_valid_q  <= 1'b0;
      imm_valid_q <= 1'b0;
      epc_q       <= 8'h00;
      retired_q   <= 16'h0000;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      ir_valid_q  <= ir_valid_d;
      imm_valid_q <= imm_valid_d;
      epc_q       <= epc_d;
      retired_q   <= retired_d;
    end
  end

  // Output drive: register contents plus combinational views of them
  always_comb begin
    bus.imem_addr = imem_addr_s;
    bus.pc        = pc_q;
    bus.ret_addr  = pc_inc_s;
    bus.ir        = ir_q;
    bus.opcode    = ir_q[7:4];
    bus.brx       = ir_q[3:2];
    bus.rb_idx    = ir_q[1:0];
    bus.imm       = imm_q;
    bus.ir_valid  = ir_valid_q;
    bus.imm_valid = imm_valid_q;
    bus.epc       = epc_q;
    bus.retired   = retired_q;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch datapath. It sits directly downstream of the PC control unit and consumes its `pc_en`/`pc_load`/`pc_src`/`addr_src`/`byte_sel`/`if_en`/`instr_done` strobes. It holds the 8-bit PC, drives the instruction-memory address, and captures the opcode byte and the optional immediate/EA byte. It presents decoded fields to the control unit and the decode stage.

## Interface
- `RESET_VEC_ADDR`, default 8'h00: memory address holding the reset vector.
- `INTR_VEC_ADDR`, default 8'h01: memory address holding the interrupt vector.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `pc_en` input 1: PC update enable.
- `pc_load` input 1: with `pc_en`, load PC from the `pc_src` mux; otherwise increment.
- `pc_src` input 2: 00 `rb_ex`, 01 `imem_rdata` (vector), 10 `rb_d`, 11 `stack_data`.
- `addr_src` input 2: 00 PC-relative fetch, 01 `RESET_VEC_ADDR`, 10 `INTR_VEC_ADDR`, 11 same as 00.
- `byte_sel` input 1: the current fetch is the second byte (immediate/EA).
- `if_en` input 1: fetch strobe.
- `instr_done` input 1: instruction retire strobe.
- `rb_ex` input 8: branch/loop target from execute.
- `rb_d` input 8: JMP/CALL target from decode.
- `stack_data` input 8: RET/RTI popped address.
- `imem_rdata` input 8: instruction memory read data, combinational on `imem_addr`.
- `imem_addr` output 8: instruction memory address.
- `pc` output 8: current PC.
- `ret_addr` output 8: `pc+1` mod 256, used by CALL and the interrupt push.
- `ir` output 8: instruction register.
- `opcode` output 4: `ir[7:4]`.
- `brx` output 2: `ir[3:2]`.
- `rb_idx` output 2: `ir[1:0]`.
- `imm` output 8: immediate/EA register.
- `ir_valid` output 1: `ir` holds a fetched instruction.
- `imm_valid` output 1: `imm` belongs to the current instruction.
- `epc` output 8: PC at the most recent interrupt vector load.
- `retired` output 16: count of retired instructions.

## Operation
- PC update priority, evaluated each rising edge:
  - `reset` → 0.
  - `pc_en & pc_load` → `pc_src` mux value.
  - `pc_en & !pc_load` → `pc+1` (8-bit wrap, FF→00).
  - Otherwise hold.
  - A `pc_load` without `pc_en` is ignored.
- `imem_addr`, combinational:
  - `addr_src`=01 → `RESET_VEC_ADDR`.
  - `addr_src`=10 → `INTR_VEC_ADDR`.
  - Otherwise `pc+1` when `pc_en & !pc_load`, else `pc`.
  - Consequence: the fetched byte is always the byte at the address the PC will hold after the edge.
  - After a load, the next fetch reads the target without incrementing.
- IR write: `if_en & !byte_sel & !pc_load` → `ir <= imem_rdata`, `ir_valid <= 1`, `imm_valid <= 0`.
- IMM write: `if_en & byte_sel` → `imm <= imem_rdata`, `imm_valid <= 1`.
- Vector load (`pc_load & pc_src==01`):
  - IR is not written.
  - `ir_valid` and `imm_valid` clear.
  - If `addr_src`=10, `epc <= pc`.
- Any other `pc_load` (branch/jump/return) leaves IR/IMM untouched. The following fetch overwrites them.
- `retired` increments on `instr_done`, saturates at 16'hFFFF, and clears only on `reset`.

## Timing
- Reset values: `pc`=0, `ir`=0, `imm`=0, `ir_valid`=0, `imm_valid`=0, `epc`=0, `retired`=0, `imem_addr`=`pc`=0.
- PC load latency: `pc` shows the new value the cycle after the strobe. `ret_addr` and the field outputs follow the registers combinationally.
- Register fetch path: `imem_rdata` is sampled on the same edge `imem_addr` is presented, so fetch latency is 1 cycle.
- Typical sequences:
  - One-byte instruction: FETCH1 then DONE, 2 cycles.
  - Two-byte instruction: FETCH1, FETCH2, DONE, 3 cycles.
  - FETCH2 increments the PC and reads `pc+1` into `imm`.
- Reset asserted mid-fetch: all state clears on that edge. A pending IR/IMM write is dropped.
- Simultaneous events:
  - `if_en & byte_sel & pc_load`: `imm` is written and the PC loads.
  - `instr_done` with a vector load: `retired` still increments.
- `addr_src`=11 is treated as 00. There is no error output.

## Test plan
- Reset then vector: hold `reset` 2 cycles with M[0]=8'h20. Release, drive the S_RESET strobes for 1 cycle → `pc`=8'h20, `ir_valid`=0, `retired`=0.
- One-byte sequential fetch: `pc`=8'h20, M[21]=8'h5A, `pc_en=1`, `if_en=1` → `imem_addr`=8'h21. Next cycle `pc`=8'h21, `ir`=8'h5A, `opcode`=5, `brx`=2, `rb_idx`=2.
- Two-byte fetch: `ir`=8'hC1 at `pc`=8'h30, M[31]=8'h7E, FETCH2 strobes → `imm`=8'h7E, `imm_valid`=1, `pc`=8'h31.
- Branch then no-increment fetch: `pc_load`, `pc_src`=00, `rb_ex`=8'h80, then FETCH1 with `pc_en=0` → `imem_addr`=8'h80 and `ir`=M[80].
- Interrupt: `pc`=8'h44, M[1]=8'hF0, `addr_src`=10, `pc_src`=01, `pc_load`/`pc_en` → `pc`=8'hF0, `epc`=8'h44, `ir_valid`=0.
- Wrap and saturate: `pc`=8'hFF with increment → `pc`=8'h00, `ret_addr`=8'h01. `retired` preset to FFFF via 65535 `instr_done` pulses, then one more pulse → stays FFFF.
